// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with bubble/stall control, exception freeze,
// sticky stall+bubble conflict flag and saturating stall/bubble event counters.
module pipe_stage_reg #(
   parameter int VAL_W      = 64,
   parameter int NVAL       = 2,
   parameter int NDST       = 2,
   parameter int CNT_W      = 16,
   parameter int FREEZE_EXC = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_cnd,
   input  logic [3:0]              in_stat,
   input  logic [3:0]              in_icode,
   input  logic [NVAL*VAL_W-1:0]   in_val,
   input  logic [NDST*4-1:0]       in_dst,
   input  logic                    stall,
   input  logic                    bubble,
   output logic                    out_cnd,
   output logic [3:0]              out_stat,
   output logic [3:0]              out_icode,
   output logic [NVAL*VAL_W-1:0]   out_val,
   output logic [NDST*4-1:0]       out_dst,
   output logic                    out_valid,
   output logic                    frozen,
   output logic                    conflict,
   output logic [CNT_W-1:0]        stall_cnt,
   output logic [CNT_W-1:0]        bubble_cnt
);

   localparam logic [3:0] STAT_HLT  = 4'h2;
   localparam logic [3:0] STAT_ADR  = 4'h3;
   localparam logic [3:0] STAT_INS  = 4'h4;
   localparam logic [3:0] STAT_BUB  = 4'h8;
   localparam logic [3:0] ICODE_NOP = 4'h1;
   localparam logic [3:0] RNONE     = 4'hF;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Declaration initialisers give bubble contents before the first reset edge.
   logic             cnd_reg        = 1'b0;
   logic [3:0]       stat_reg       = STAT_BUB;
   logic [3:0]       icode_reg      = ICODE_NOP;
   logic             valid_reg      = 1'b0;
   logic             conflict_reg   = 1'b0;
   logic [CNT_W-1:0] stall_cnt_reg  = '0;
   logic [CNT_W-1:0] bubble_cnt_reg = '0;
   logic             frozen_reg;

   logic clr_en;
   logic load_en;
   logic in_exc;

   always_comb begin
      clr_en  = reset || bubble;
      load_en = !clr_en && !stall && !frozen_reg;
      in_exc  = (in_stat == STAT_HLT) || (in_stat == STAT_ADR) || (in_stat == STAT_INS);
   end

   always_ff @(posedge clk) begin
      if (clr_en) begin
         cnd_reg   <= 1'b0;
         stat_reg  <= STAT_BUB;
         icode_reg <= ICODE_NOP;
         valid_reg <= 1'b0;
      end else if (load_en) begin
         cnd_reg   <= in_cnd;
         stat_reg  <= in_stat;
         icode_reg <= in_icode;
         valid_reg <= (in_stat != STAT_BUB);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NVAL; gi++) begin : g_val
         logic [VAL_W-1:0] val_reg = '0;
         always_ff @(posedge clk) begin
            if (clr_en)
               val_reg <= '0;
            else if (load_en)
               val_reg <= in_val[gi*VAL_W +: VAL_W];
         end
         assign out_val[gi*VAL_W +: VAL_W] = val_reg;
      end

      for (gi = 0; gi < NDST; gi++) begin : g_dst
         logic [3:0] dst_reg = RNONE;
         always_ff @(posedge clk) begin
            if (clr_en)
               dst_reg <= RNONE;
            else if (load_en)
               dst_reg <= in_dst[gi*4 +: 4];
         end
         assign out_dst[gi*4 +: 4] = dst_reg;
      end

      // Freeze is only released by reset or an explicit bubble.
      if (FREEZE_EXC != 0) begin : g_freeze
         logic frozen_q = 1'b0;
         always_ff @(posedge clk) begin
            if (clr_en)
               frozen_q <= 1'b0;
            else if (load_en && in_exc)
               frozen_q <= 1'b1;
         end
         assign frozen_reg = frozen_q;
      end else begin : g_no_freeze
         assign frozen_reg = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_reg   <= 1'b0;
         stall_cnt_reg  <= '0;
         bubble_cnt_reg <= '0;
      end else begin
         if (stall && bubble)
            conflict_reg <= 1'b1;
         if (stall && !bubble && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
         if (bubble && (bubble_cnt_reg != '1))
            bubble_cnt_reg <= bubble_cnt_reg + CNT_ONE;
      end
   end

   assign out_cnd    = cnd_reg;
   assign out_stat   = stat_reg;
   assign out_icode  = icode_reg;
   assign out_valid  = valid_reg;
   assign frozen     = frozen_reg;
   assign conflict   = conflict_reg;
   assign stall_cnt  = stall_cnt_reg;
   assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a 4-bit-counter
// instance and a no-freeze instance sharing the same stimulus.
module tb_pipe_stage_reg;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_cnd = 1'b0;
   logic [3:0]   in_stat = 4'h1;
   logic [3:0]   in_icode = 4'h0;
   logic [127:0] in_val = '0;
   logic [7:0]   in_dst = 8'hFF;
   logic         stall = 1'b0;
   logic         bubble = 1'b0;

   logic         out_cnd, out_valid, frozen, conflict;
   logic [3:0]   out_stat, out_icode;
   logic [127:0] out_val;
   logic [7:0]   out_dst;
   logic [15:0]  stall_cnt, bubble_cnt;

   logic         s_cnd, s_valid, s_frozen, s_conflict;
   logic [3:0]   s_stat, s_icode;
   logic [127:0] s_val;
   logic [7:0]   s_dst;
   logic [3:0]   s_stall_cnt, s_bubble_cnt;

   logic         n_cnd, n_valid, n_frozen, n_conflict;
   logic [3:0]   n_stat, n_icode;
   logic [127:0] n_val;
   logic [7:0]   n_dst;
   logic [15:0]  n_stall_cnt, n_bubble_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .reset(reset), .in_cnd(in_cnd), .in_stat(in_stat), .in_icode(in_icode),
      .in_val(in_val), .in_dst(in_dst), .stall(stall), .bubble(bubble),
      .out_cnd(out_cnd), .out_stat(out_stat), .out_icode(out_icode), .out_val(out_val),
      .out_dst(out_dst), .out_valid(out_valid), .frozen(frozen), .conflict(conflict),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_reg #(.CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .in_cnd(in_cnd), .in_stat(in_stat), .in_icode(in_icode),
      .in_val(in_val), .in_dst(in_dst), .stall(stall), .bubble(bubble),
      .out_cnd(s_cnd), .out_stat(s_stat), .out_icode(s_icode), .out_val(s_val),
      .out_dst(s_dst), .out_valid(s_valid), .frozen(s_frozen), .conflict(s_conflict),
      .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
   );

   pipe_stage_reg #(.FREEZE_EXC(0)) dut_n (
      .clk(clk), .reset(reset), .in_cnd(in_cnd), .in_stat(in_stat), .in_icode(in_icode),
      .in_val(in_val), .in_dst(in_dst), .stall(stall), .bubble(bubble),
      .out_cnd(n_cnd), .out_stat(n_stat), .out_icode(n_icode), .out_val(n_val),
      .out_dst(n_dst), .out_valid(n_valid), .frozen(n_frozen), .conflict(n_conflict),
      .stall_cnt(n_stall_cnt), .bubble_cnt(n_bubble_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      $display("t=%0t rst=%b stall=%b bub=%b in_stat=%h -> stat=%h icode=%h valid=%b frozen=%b conflict=%b scnt=%0d bcnt=%0d",
               $time, reset, stall, bubble, in_stat, out_stat, out_icode, out_valid, frozen, conflict, stall_cnt, bubble_cnt);
   endtask

   task automatic test_power_on();
      #1;
      checks++;
      if (out_stat !== 4'h8) begin
         failures++;
         $display("FAIL power_on_stat: got %h want 8", out_stat);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; bubble = 1'b0; stall = 1'b0;
      tick();
      checks++;
      if ({out_cnd, out_stat, out_icode, out_valid} !== {1'b0, 4'h8, 4'h1, 1'b0}) begin
         failures++;
         $display("FAIL reset_ctrl: got cnd=%b stat=%h icode=%h valid=%b want 0/8/1/0", out_cnd, out_stat, out_icode, out_valid);
      end
      checks++;
      if ({out_val, out_dst} !== {128'h0, 8'hFF}) begin
         failures++;
         $display("FAIL reset_data: got val=%h dst=%h want 0/ff", out_val, out_dst);
      end
      checks++;
      if ({frozen, conflict, stall_cnt, bubble_cnt} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
         failures++;
         $display("FAIL reset_status: got frozen=%b conflict=%b scnt=%0d bcnt=%0d want 0/0/0/0", frozen, conflict, stall_cnt, bubble_cnt);
      end
   endtask

   task automatic test_load();
      reset = 1'b0;
      in_cnd = 1'b1; in_stat = 4'h1; in_icode = 4'h6;
      in_val = {64'hA, 64'h5}; in_dst = {4'h3, 4'h2};
      tick();
      checks++;
      if ({out_cnd, out_stat, out_icode, out_valid} !== {1'b1, 4'h1, 4'h6, 1'b1}) begin
         failures++;
         $display("FAIL load_ctrl: got cnd=%b stat=%h icode=%h valid=%b want 1/1/6/1", out_cnd, out_stat, out_icode, out_valid);
      end
      checks++;
      if ({out_val, out_dst} !== {64'hA, 64'h5, 8'h32}) begin
         failures++;
         $display("FAIL load_data: got val=%h dst=%h want a/5 32", out_val, out_dst);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_cnd = 1'b0; in_stat = 4'h1; in_icode = 4'h7 + 4'(i);
         in_val = {64'h11 + 64'(i), 64'h22}; in_dst = 8'h45;
         tick();
      end
      stall = 1'b0;
      checks++;
      if ({out_cnd, out_stat, out_icode, out_valid, out_val, out_dst} !== {1'b1, 4'h1, 4'h6, 1'b1, 64'hA, 64'h5, 8'h32}) begin
         failures++;
         $display("FAIL stall_hold: got stat=%h icode=%h val=%h dst=%h want 1/6 a/5 32", out_stat, out_icode, out_val, out_dst);
      end
      checks++;
      if ({stall_cnt, bubble_cnt} !== {16'd3, 16'd0}) begin
         failures++;
         $display("FAIL stall_counts: got scnt=%0d bcnt=%0d want 3/0", stall_cnt, bubble_cnt);
      end
   endtask

   task automatic test_conflict();
      stall = 1'b1; bubble = 1'b1;
      tick();
      stall = 1'b0; bubble = 1'b0;
      checks++;
      if ({out_stat, out_icode, out_dst, out_valid, out_val} !== {4'h8, 4'h1, 8'hFF, 1'b0, 128'h0}) begin
         failures++;
         $display("FAIL conflict_bubble: got stat=%h icode=%h dst=%h valid=%b want 8/1/ff/0", out_stat, out_icode, out_dst, out_valid);
      end
      checks++;
      if ({conflict, stall_cnt, bubble_cnt} !== {1'b1, 16'd3, 16'd1}) begin
         failures++;
         $display("FAIL conflict_counts: got conflict=%b scnt=%0d bcnt=%0d want 1/3/1", conflict, stall_cnt, bubble_cnt);
      end
      in_stat = 4'h1; in_icode = 4'h2; in_dst = 8'h10;
      tick();
      checks++;
      if ({conflict, out_valid, out_icode} !== {1'b1, 1'b1, 4'h2}) begin
         failures++;
         $display("FAIL conflict_sticky: got conflict=%b valid=%b icode=%h want 1/1/2", conflict, out_valid, out_icode);
      end
   endtask

   task automatic test_bubble_stat_load();
      in_stat = 4'h8; in_icode = 4'h3;
      tick();
      checks++;
      if ({out_stat, out_icode, out_valid} !== {4'h8, 4'h3, 1'b0}) begin
         failures++;
         $display("FAIL load_bub_stat: got stat=%h icode=%h valid=%b want 8/3/0", out_stat, out_icode, out_valid);
      end
   endtask

   task automatic test_freeze();
      in_stat = 4'h3; in_icode = 4'h5; in_val = {64'h0, 64'h7};
      tick();
      checks++;
      if ({out_stat, frozen, n_frozen} !== {4'h3, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL freeze_set: got stat=%h frozen=%b nofreeze_frozen=%b want 3/1/0", out_stat, frozen, n_frozen);
      end
      in_stat = 4'h1; in_icode = 4'h9;
      tick();
      tick();
      checks++;
      if ({out_stat, out_icode, frozen, out_val} !== {4'h3, 4'h5, 1'b1, 64'h0, 64'h7}) begin
         failures++;
         $display("FAIL freeze_hold: got stat=%h icode=%h frozen=%b val=%h want 3/5/1 0/7", out_stat, out_icode, frozen, out_val);
      end
      checks++;
      if ({n_stat, n_icode, n_frozen} !== {4'h1, 4'h9, 1'b0}) begin
         failures++;
         $display("FAIL nofreeze_load: got stat=%h icode=%h frozen=%b want 1/9/0", n_stat, n_icode, n_frozen);
      end
      checks++;
      if (stall_cnt !== 16'd3) begin
         failures++;
         $display("FAIL freeze_no_stall_count: got scnt=%0d want 3", stall_cnt);
      end
      bubble = 1'b1;
      tick();
      bubble = 1'b0;
      checks++;
      if ({out_stat, out_icode, out_valid, frozen, bubble_cnt} !== {4'h8, 4'h1, 1'b0, 1'b0, 16'd2}) begin
         failures++;
         $display("FAIL freeze_release: got stat=%h icode=%h valid=%b frozen=%b bcnt=%0d want 8/1/0/0/2", out_stat, out_icode, out_valid, frozen, bubble_cnt);
      end
      tick();
      checks++;
      if ({out_stat, out_icode, out_valid} !== {4'h1, 4'h9, 1'b1}) begin
         failures++;
         $display("FAIL post_release_load: got stat=%h icode=%h valid=%b want 1/9/1", out_stat, out_icode, out_valid);
      end
   endtask

   task automatic test_reset_mid_freeze();
      in_stat = 4'h4; in_icode = 4'hB;
      tick();
      checks++;
      if ({out_stat, frozen} !== {4'h4, 1'b1}) begin
         failures++;
         $display("FAIL ins_freeze: got stat=%h frozen=%b want 4/1", out_stat, frozen);
      end
      reset = 1'b1; stall = 1'b1; in_stat = 4'h1; in_icode = 4'h6;
      tick();
      checks++;
      if ({out_stat, out_icode, out_valid, out_dst, frozen, conflict, stall_cnt, bubble_cnt} !==
          {4'h8, 4'h1, 1'b0, 8'hFF, 1'b0, 1'b0, 16'd0, 16'd0}) begin
         failures++;
         $display("FAIL reset_mid_freeze: got stat=%h icode=%h valid=%b frozen=%b conflict=%b scnt=%0d bcnt=%0d want 8/1/0/0/0/0/0",
                  out_stat, out_icode, out_valid, frozen, conflict, stall_cnt, bubble_cnt);
      end
      reset = 1'b0; stall = 1'b0;
      tick();
      checks++;
      if ({out_stat, out_icode, out_valid, frozen} !== {4'h1, 4'h6, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL load_after_reset: got stat=%h icode=%h valid=%b frozen=%b want 1/6/1/0", out_stat, out_icode, out_valid, frozen);
      end
   endtask

   task automatic test_saturation();
      stall = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      stall = 1'b0;
      checks++;
      if (s_stall_cnt !== 4'hF) begin
         failures++;
         $display("FAIL sat_cnt4: got scnt=%h want f", s_stall_cnt);
      end
      checks++;
      if (stall_cnt !== 16'd20) begin
         failures++;
         $display("FAIL cnt16_after_20: got scnt=%0d want 20", stall_cnt);
      end
   endtask

   initial begin
      test_power_on();
      test_reset();
      test_load();
      test_stall();
      test_conflict();
      test_bubble_stat_load();
      test_freeze();
      test_reset_mid_freeze();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
